// File: rtl/onchip_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_arb_pkg
//  Brief    : Shared types, default geometry and config check for the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package onchip_arb_pkg;

    localparam int unsigned C_ADDR_W   = 15;
    localparam int unsigned C_DEPTH    = 25000;
    localparam int unsigned C_CAP_BASE = 16384;
    localparam int unsigned C_CAP_LEN  = 8192;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_CAP  = 2'd1,
        GRANT_HOST = 2'd2
    } grant_t;

    function automatic bit ring_fits(int unsigned base, int unsigned len, int unsigned depth);
        return (base + len) <= depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_arbiter_if
//  Brief    : Capture stream, host Avalon-MM slave and memory port bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface onchip_mem_arbiter_if
    import onchip_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = C_ADDR_W
);
    logic              cap_valid;
    logic [31:0]       cap_data;
    logic              cap_ready;
    logic              cap_enable;
    logic              cap_clear;
    logic [ADDR_W-1:0] cap_wr_ptr;
    logic              cap_wrap;

    logic [ADDR_W-1:0] host_address;
    logic              host_read;
    logic              host_write;
    logic [3:0]        host_byteenable;
    logic [31:0]       host_writedata;
    logic              host_waitrequest;
    logic [31:0]       host_readdata;
    logic              host_readdatavalid;

    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    // Arbiter side
    modport slave (
        input  cap_valid, cap_data, cap_enable, cap_clear,
        output cap_ready, cap_wr_ptr, cap_wrap,
        input  host_address, host_read, host_write, host_byteenable, host_writedata,
        output host_waitrequest, host_readdata, host_readdatavalid,
        output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
        input  mem_readdata
    );

    // Requester / memory side
    modport master (
        output cap_valid, cap_data, cap_enable, cap_clear,
        input  cap_ready, cap_wr_ptr, cap_wrap,
        output host_address, host_read, host_write, host_byteenable, host_writedata,
        input  host_waitrequest, host_readdata, host_readdatavalid,
        input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
        output mem_readdata
    );

endinterface
`default_nettype wire

// File: rtl/onchip_mem_arbiter_cap_ring_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : cap_ring_ptr
//  Brief    : Circular capture write pointer with clear priority and wrap pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module cap_ring_ptr
    import onchip_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = C_ADDR_W,
    parameter int unsigned CAP_LEN = C_CAP_LEN
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              wrap_o
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wrap_q, wrap_d;
    logic              w_at_end;

    assign w_at_end = (ptr_q == ADDR_W'(CAP_LEN - 1));

    // Clear beats increment and never produces a wrap pulse.
    always_comb begin
        ptr_d  = ptr_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            if (w_at_end) begin
                ptr_d  = '0;
                wrap_d = 1'b1;
            end else begin
                ptr_d = ptr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            wrap_q <= wrap_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign wrap_o = wrap_q;

endmodule
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : onchip_mem_arbiter
//  Brief    : Round-robin share of a single-port RAM between capture and host.
//  Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = C_ADDR_W,
    parameter int unsigned DEPTH    = C_DEPTH,
    parameter int unsigned CAP_BASE = C_CAP_BASE,
    parameter int unsigned CAP_LEN  = C_CAP_LEN
) (
    input  logic                clk,
    input  logic                reset_n,
    onchip_mem_arbiter_if.slave bus
);

    logic              w_cap_req, w_host_req, w_host_in_range;
    logic              w_cap_grant, w_host_grant;
    grant_t            w_grant;
    grant_t            last_grant_q, last_grant_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_oor_q, rd_oor_d;
    logic [ADDR_W-1:0] w_ptr;

    if (!ring_fits(CAP_BASE, CAP_LEN, DEPTH)) begin : g_cfg_check
        $error("onchip_mem_arbiter: capture ring exceeds memory depth");
    end

    assign w_cap_req       = bus.cap_valid & bus.cap_enable;
    assign w_host_req      = bus.host_read | bus.host_write;
    assign w_host_in_range = (32'(bus.host_address) < DEPTH);

    // Under contention the requester not served last time wins.
    always_comb begin
        w_grant = GRANT_NONE;
        if (reset_n) begin
            if (w_cap_req && (!w_host_req || last_grant_q == GRANT_HOST)) begin
                w_grant = GRANT_CAP;
            end else if (w_host_req) begin
                w_grant = GRANT_HOST;
            end
        end
    end

    assign w_cap_grant  = (w_grant == GRANT_CAP);
    assign w_host_grant = (w_grant == GRANT_HOST);
    assign last_grant_d = (w_grant == GRANT_NONE) ? last_grant_q : w_grant;
    assign rd_pend_d    = w_host_grant & bus.host_read;
    assign rd_oor_d     = ~w_host_in_range;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= GRANT_HOST;
            rd_pend_q    <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_oor_q     <= rd_oor_d;
        end
    end

    cap_ring_ptr #(
        .ADDR_W  (ADDR_W),
        .CAP_LEN (CAP_LEN)
    ) u_cap_ring_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (w_cap_grant),
        .clr_i   (bus.cap_clear),
        .ptr_o   (w_ptr),
        .wrap_o  (bus.cap_wrap)
    );

    assign bus.cap_ready  = w_cap_grant;
    assign bus.cap_wr_ptr = w_ptr;

    assign bus.host_waitrequest   = w_host_req & ~w_host_grant;
    assign bus.host_readdatavalid = rd_pend_q;
    assign bus.host_readdata      = (rd_pend_q && !rd_oor_q) ? bus.mem_readdata : 32'h0;

    // Out-of-range host accesses are granted but never reach the RAM.
    assign bus.mem_address    = w_cap_grant ? (ADDR_W'(CAP_BASE) + w_ptr) : bus.host_address;
    assign bus.mem_byteenable = w_cap_grant ? 4'hF : bus.host_byteenable;
    assign bus.mem_writedata  = w_cap_grant ? bus.cap_data : bus.host_writedata;
    assign bus.mem_chipselect = w_cap_grant | (w_host_grant & w_host_in_range);
    assign bus.mem_write      = w_cap_grant | (w_host_grant & bus.host_write & w_host_in_range);
    assign bus.mem_clken      = reset_n;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_onchip_mem_arbiter
//  Brief    : Self-checking bench with RAM model and transaction-level reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_arbiter;
    import onchip_arb_pkg::*;

    localparam int unsigned DEPTH    = 25000;
    localparam int unsigned CAP_BASE = 16384;
    localparam int unsigned CAP_LEN  = 8192;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter_if #(.ADDR_W(15)) bus ();

    onchip_mem_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Single-port RAM with byte enables and one-cycle registered read
    logic [31:0] ram [0:DEPTH-1];
    initial begin
        logic [31:0] w;
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = 32'h0;
        bus.mem_readdata = 32'h0;
        forever begin
            @(posedge clk);
            if (bus.mem_clken && bus.mem_chipselect && 32'(bus.mem_address) < DEPTH) begin
                if (bus.mem_write) begin
                    w = ram[bus.mem_address];
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_byteenable[b]) w[8*b +: 8] = bus.mem_writedata[8*b +: 8];
                    ram[bus.mem_address] <= w;
                end else begin
                    bus.mem_readdata <= ram[bus.mem_address];
                end
            end
        end
    end

    // Reference model state
    int          m_ptr;
    bit          m_wrap, m_last_host, m_rv;
    logic [31:0] m_rdata;
    logic [31:0] ref_mem [0:DEPTH-1];
    bit          e_cap, e_host, e_wait, e_cs, e_we;
    logic [14:0] e_addr;

    task automatic model_reset();
        m_ptr = 0; m_wrap = 0; m_last_host = 1; m_rv = 0; m_rdata = 32'h0;
    endtask

    task automatic model_eval();
        bit creq, hreq, inr;
        creq   = bus.cap_valid && bus.cap_enable;
        hreq   = bus.host_read || bus.host_write;
        inr    = 32'(bus.host_address) < DEPTH;
        e_cap  = creq && (!hreq || m_last_host);
        e_host = hreq && !e_cap;
        e_wait = hreq && !e_host;
        e_cs   = e_cap || (e_host && inr);
        e_we   = e_cap || (e_host && bus.host_write && inr);
        e_addr = e_cap ? 15'(CAP_BASE + m_ptr) : bus.host_address;
    endtask

    task automatic model_commit();
        bit inr;
        inr  = 32'(bus.host_address) < DEPTH;
        m_rv = e_host && bus.host_read;
        m_rdata = (m_rv && inr) ? ref_mem[bus.host_address] : 32'h0;
        if (e_cap) ref_mem[CAP_BASE + m_ptr] = bus.cap_data;
        if (e_host && bus.host_write && inr)
            for (int b = 0; b < 4; b++)
                if (bus.host_byteenable[b]) ref_mem[bus.host_address][8*b +: 8] = bus.host_writedata[8*b +: 8];
        m_wrap = 0;
        if (bus.cap_clear) m_ptr = 0;
        else if (e_cap) begin
            m_ptr  = (m_ptr + 1) % int'(CAP_LEN);
            m_wrap = (m_ptr == 0);
        end
        if (e_cap) m_last_host = 0;
        else if (e_host) m_last_host = 1;
    endtask

    task automatic set_idle();
        bus.cap_valid = 0; bus.cap_data = 32'h0; bus.cap_enable = 0; bus.cap_clear = 0;
        bus.host_address = 15'h0; bus.host_read = 0; bus.host_write = 0;
        bus.host_byteenable = 4'h0; bus.host_writedata = 32'h0;
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        model_commit();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 0;
        @(posedge clk); #1;
        reset_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        set_idle();
        bus.cap_valid = 1; bus.cap_enable = 1; bus.host_read = 1; bus.host_address = 15'd5;
        @(negedge clk);
        checks++; if (bus.cap_ready !== 1'b0) begin errors++; $display("FAIL reset_cap_ready: got %b want 0", bus.cap_ready); end
        checks++; if (bus.host_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitrequest: got %b want 1", bus.host_waitrequest); end
        checks++; if (bus.mem_clken !== 1'b0) begin errors++; $display("FAIL reset_clken: got %b want 0", bus.mem_clken); end
        checks++; if ({bus.mem_chipselect, bus.mem_write} !== 2'b00) begin errors++; $display("FAIL reset_cs_we: got %b want 00", {bus.mem_chipselect, bus.mem_write}); end
        checks++; if ({bus.host_readdatavalid, bus.host_readdata} !== 33'h0) begin errors++; $display("FAIL reset_rdata: got %b/%h want 0/0", bus.host_readdatavalid, bus.host_readdata); end
        checks++; if ({bus.cap_wr_ptr, bus.cap_wrap} !== 16'h0) begin errors++; $display("FAIL reset_ptr_wrap: got %0d/%b want 0/0", bus.cap_wr_ptr, bus.cap_wrap); end
        @(posedge clk); #1;
        set_idle();
        reset_n = 1;
        model_reset();
        @(negedge clk);
        checks++; if (bus.mem_clken !== 1'b1) begin errors++; $display("FAIL run_clken: got %b want 1", bus.mem_clken); end
        model_eval(); model_commit();
        @(posedge clk); #1;
    endtask

    task automatic test_capture_only();
        int wraps, bad;
        wraps = 0;
        set_idle(); bus.cap_enable = 1;
        for (int i = 0; i < 8; i++) begin
            bus.cap_valid = 1; bus.cap_data = 32'hA0 + 32'(i);
            @(negedge clk);
            checks++;
            if (bus.cap_ready !== 1'b1 || bus.mem_address !== 15'(16384 + i) || bus.mem_write !== 1'b1 ||
                bus.mem_chipselect !== 1'b1 || bus.mem_byteenable !== 4'hF) begin
                errors++; $display("FAIL cap_write[%0d]: got rdy=%b addr=%0d we=%b cs=%b be=%h want 1/%0d/1/1/f",
                                   i, bus.cap_ready, bus.mem_address, bus.mem_write, bus.mem_chipselect, bus.mem_byteenable, 16384 + i);
            end
            if (bus.cap_wrap) wraps++;
            model_eval(); model_commit();
            @(posedge clk); #1;
        end
        bus.cap_valid = 0;
        @(negedge clk);
        if (bus.cap_wrap) wraps++;
        checks++; if (bus.cap_wr_ptr !== 15'd8) begin errors++; $display("FAIL cap_ptr8: got %0d want 8", bus.cap_wr_ptr); end
        checks++; if (wraps != 0) begin errors++; $display("FAIL cap_no_wrap: got %0d pulses want 0", wraps); end
        model_eval(); model_commit();
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 8; i++) if (ram[16384 + i] !== 32'hA0 + 32'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL cap_ram_content: got %0d bad words want 0", bad); end
    endtask

    task automatic test_wrap();
        int exp_a [3];
        int wraps, wrap_at;
        exp_a[0] = 24574; exp_a[1] = 24575; exp_a[2] = 16384;
        set_idle();
        bus.cap_clear = 1;
        step();
        bus.cap_clear = 0; bus.cap_enable = 1; bus.cap_valid = 1;
        for (int i = 0; i < 8190; i++) begin
            bus.cap_data = 32'(i);
            step();
        end
        wraps = 0; wrap_at = -1;
        for (int i = 0; i < 3; i++) begin
            bus.cap_data = 32'hB0 + 32'(i);
            @(negedge clk);
            if (i == 0) begin
                checks++; if (bus.cap_wr_ptr !== 15'd8190) begin errors++; $display("FAIL wrap_preload: got %0d want 8190", bus.cap_wr_ptr); end
            end
            checks++; if (bus.mem_address !== 15'(exp_a[i])) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, bus.mem_address, exp_a[i]); end
            if (bus.cap_wrap) begin wraps++; wrap_at = i; end
            model_eval(); model_commit();
            @(posedge clk); #1;
        end
        bus.cap_valid = 0;
        @(negedge clk);
        if (bus.cap_wrap) begin wraps++; wrap_at = 3; end
        checks++; if (wraps != 1 || wrap_at != 2) begin errors++; $display("FAIL wrap_pulse: got %0d pulses at %0d want 1 at 2", wraps, wrap_at); end
        checks++; if (bus.cap_wr_ptr !== 15'd1) begin errors++; $display("FAIL wrap_ptr: got %0d want 1", bus.cap_wr_ptr); end
        model_eval(); model_commit();
        @(posedge clk); #1;
        checks++; if (ram[24575] !== 32'hB1 || ram[16384] !== 32'hB2) begin errors++; $display("FAIL wrap_ram: got %h/%h want b1/b2", ram[24575], ram[16384]); end
    endtask

    task automatic test_contention();
        int run;
        bit exp_rv;
        do_reset();
        bus.cap_enable = 1; bus.cap_valid = 1; bus.host_read = 1;
        bus.host_address = 15'($urandom_range(0, DEPTH - 1));
        run = 0;
        for (int i = 0; i < 20; i++) begin
            bus.cap_data = $urandom;
            exp_rv = (i > 0) && (i % 2 == 0);
            @(negedge clk);
            model_eval();
            checks++; if (bus.cap_ready !== (i % 2 == 0)) begin errors++; $display("FAIL cont_ready[%0d]: got %b want %b", i, bus.cap_ready, (i % 2 == 0)); end
            checks++; if (bus.host_waitrequest !== (i % 2 == 0)) begin errors++; $display("FAIL cont_wait[%0d]: got %b want %b", i, bus.host_waitrequest, (i % 2 == 0)); end
            checks++; if (bus.host_readdatavalid !== exp_rv) begin errors++; $display("FAIL cont_rv[%0d]: got %b want %b", i, bus.host_readdatavalid, exp_rv); end
            if (exp_rv) begin
                checks++; if (bus.host_readdata !== m_rdata) begin errors++; $display("FAIL cont_rdata[%0d]: got %h want %h", i, bus.host_readdata, m_rdata); end
            end
            run = bus.host_waitrequest ? run + 1 : 0;
            checks++; if (run > 1) begin errors++; $display("FAIL cont_stall[%0d]: got run %0d want <=1", i, run); end
            model_commit();
            @(posedge clk); #1;
            if (e_host) bus.host_address = 15'($urandom_range(0, DEPTH - 1));
        end
        set_idle();
        step();
    endtask

    task automatic test_host_rw();
        set_idle();
        bus.host_write = 1; bus.host_address = 15'd100; bus.host_writedata = 32'h12345678; bus.host_byteenable = 4'b0011;
        @(negedge clk);
        model_eval();
        checks++;
        if (bus.host_waitrequest !== 1'b0 || bus.mem_chipselect !== 1'b1 || bus.mem_write !== 1'b1 ||
            bus.mem_address !== 15'd100 || bus.mem_byteenable !== 4'b0011 || bus.mem_writedata !== 32'h12345678) begin
            errors++; $display("FAIL host_wr_port: got wait=%b cs=%b we=%b addr=%0d be=%b wd=%h want 0/1/1/100/0011/12345678",
                               bus.host_waitrequest, bus.mem_chipselect, bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.mem_writedata);
        end
        model_commit();
        @(posedge clk); #1;
        bus.host_write = 0; bus.host_read = 1;
        @(negedge clk);
        model_eval();
        checks++; if ({bus.host_waitrequest, bus.mem_chipselect, bus.mem_write} !== 3'b010) begin errors++; $display("FAIL host_rd_port: got %b want 010", {bus.host_waitrequest, bus.mem_chipselect, bus.mem_write}); end
        model_commit();
        @(posedge clk); #1;
        bus.host_read = 0;
        @(negedge clk);
        model_eval();
        checks++; if (bus.host_readdatavalid !== 1'b1) begin errors++; $display("FAIL host_rd_valid: got %b want 1", bus.host_readdatavalid); end
        checks++; if (bus.host_readdata[15:0] !== 16'h5678) begin errors++; $display("FAIL host_rd_lanes: got %h want 5678", bus.host_readdata[15:0]); end
        checks++; if (bus.host_readdata !== m_rdata) begin errors++; $display("FAIL host_rd_word: got %h want %h", bus.host_readdata, m_rdata); end
        model_commit();
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        int bad;
        set_idle();
        bus.host_read = 1; bus.host_address = 15'd25000;
        @(negedge clk);
        model_eval();
        checks++; if ({bus.host_waitrequest, bus.mem_chipselect} !== 2'b00) begin errors++; $display("FAIL oor_rd_cs: got wait/cs %b want 00", {bus.host_waitrequest, bus.mem_chipselect}); end
        model_commit();
        @(posedge clk); #1;
        bus.host_read = 0; bus.host_write = 1; bus.host_address = 15'd30000;
        bus.host_writedata = 32'hDEADBEEF; bus.host_byteenable = 4'hF;
        @(negedge clk);
        model_eval();
        checks++; if ({bus.host_readdatavalid, bus.host_readdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL oor_rd_data: got %b/%h want 1/0", bus.host_readdatavalid, bus.host_readdata); end
        checks++; if ({bus.host_waitrequest, bus.mem_chipselect, bus.mem_write} !== 3'b000) begin errors++; $display("FAIL oor_wr_port: got %b want 000", {bus.host_waitrequest, bus.mem_chipselect, bus.mem_write}); end
        model_commit();
        @(posedge clk); #1;
        set_idle();
        step();
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== ref_mem[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL oor_ram_intact: got %0d differing words want 0", bad); end
    endtask

    task automatic test_clear_coincident();
        do_reset();
        bus.cap_enable = 1; bus.cap_valid = 1;
        for (int i = 0; i < 5; i++) begin bus.cap_data = 32'hC0 + 32'(i); step(); end
        bus.cap_data = 32'hC1EA0005; bus.cap_clear = 1;
        @(negedge clk);
        model_eval();
        checks++; if (bus.cap_ready !== 1'b1 || bus.mem_address !== 15'(16389)) begin errors++; $display("FAIL clr_write: got rdy=%b addr=%0d want 1/16389", bus.cap_ready, bus.mem_address); end
        model_commit();
        @(posedge clk); #1;
        bus.cap_valid = 0; bus.cap_clear = 0;
        @(negedge clk);
        model_eval();
        checks++; if ({bus.cap_wr_ptr, bus.cap_wrap} !== 16'h0) begin errors++; $display("FAIL clr_ptr: got %0d/%b want 0/0", bus.cap_wr_ptr, bus.cap_wrap); end
        checks++; if (ram[16389] !== 32'hC1EA0005) begin errors++; $display("FAIL clr_ram: got %h want c1ea0005", ram[16389]); end
        model_commit();
        @(posedge clk); #1;
    endtask

    task automatic test_enable_low();
        set_idle();
        bus.cap_valid = 1; bus.cap_enable = 0; bus.cap_data = 32'h5A5A5A5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            model_eval();
            checks++; if (bus.cap_ready !== 1'b0 || bus.mem_chipselect !== 1'b0) begin errors++; $display("FAIL en_low[%0d]: got rdy=%b cs=%b want 0/0", i, bus.cap_ready, bus.mem_chipselect); end
            checks++; if (bus.cap_wr_ptr !== 15'(m_ptr)) begin errors++; $display("FAIL en_low_ptr[%0d]: got %0d want %0d", i, bus.cap_wr_ptr, m_ptr); end
            model_commit();
            @(posedge clk); #1;
        end
        bus.cap_enable = 1;
        @(negedge clk);
        model_eval();
        checks++; if (bus.cap_ready !== 1'b1) begin errors++; $display("FAIL en_high: got %b want 1", bus.cap_ready); end
        model_commit();
        @(posedge clk); #1;
        set_idle();
    endtask

    task automatic test_random();
        int bad;
        set_idle();
        for (int c = 0; c < 800; c++) begin
            bus.cap_valid  = ($urandom_range(0, 3) != 0);
            bus.cap_enable = ($urandom_range(0, 7) != 0);
            bus.cap_data   = $urandom;
            bus.cap_clear  = ($urandom_range(0, 31) == 0);
            if (!bus.host_read && !bus.host_write) begin
                case ($urandom_range(0, 5))
                    0: bus.host_read = 1;
                    1: bus.host_write = 1;
                    default: ;
                endcase
                case ($urandom_range(0, 3))
                    0: bus.host_address = 15'($urandom_range(0, 63));
                    1: bus.host_address = 15'(CAP_BASE + $urandom_range(0, 15));
                    2: bus.host_address = 15'($urandom_range(DEPTH, 32767));
                    default: bus.host_address = 15'($urandom_range(0, DEPTH - 1));
                endcase
                bus.host_byteenable = 4'($urandom);
                bus.host_writedata  = $urandom;
            end
            @(negedge clk);
            model_eval();
            checks++;
            if (bus.cap_ready !== e_cap || bus.host_waitrequest !== e_wait || bus.mem_chipselect !== e_cs) begin
                errors++; $display("FAIL rnd_grant[%0d]: got rdy/wait/cs %b%b%b want %b%b%b", c,
                                   bus.cap_ready, bus.host_waitrequest, bus.mem_chipselect, e_cap, e_wait, e_cs);
            end
            if (e_cs) begin
                checks++; if (bus.mem_address !== e_addr || bus.mem_write !== e_we) begin errors++; $display("FAIL rnd_mem[%0d]: got addr=%0d we=%b want %0d/%b", c, bus.mem_address, bus.mem_write, e_addr, e_we); end
            end
            checks++; if (bus.host_readdatavalid !== m_rv) begin errors++; $display("FAIL rnd_rv[%0d]: got %b want %b", c, bus.host_readdatavalid, m_rv); end
            if (m_rv) begin
                checks++; if (bus.host_readdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, bus.host_readdata, m_rdata); end
            end
            checks++; if (bus.cap_wr_ptr !== 15'(m_ptr) || bus.cap_wrap !== m_wrap) begin errors++; $display("FAIL rnd_ptr[%0d]: got %0d/%b want %0d/%b", c, bus.cap_wr_ptr, bus.cap_wrap, m_ptr, m_wrap); end
            model_commit();
            @(posedge clk); #1;
            if (e_host) begin bus.host_read = 0; bus.host_write = 0; end
        end
        set_idle();
        step();
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== ref_mem[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rnd_ram: got %0d differing words want 0", bad); end
    endtask

    task automatic test_reset_mid_read();
        set_idle();
        bus.host_read = 1; bus.host_address = 15'd100;
        @(negedge clk);
        model_eval();
        checks++; if (bus.host_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_accept: got wait %b want 0", bus.host_waitrequest); end
        model_commit();
        @(posedge clk); #1;
        reset_n = 0;
        bus.host_read = 0;
        @(negedge clk);
        checks++; if ({bus.host_readdatavalid, bus.host_readdata} !== 33'h0) begin errors++; $display("FAIL mid_drop: got %b/%h want 0/0", bus.host_readdatavalid, bus.host_readdata); end
        @(posedge clk); #1;
        reset_n = 1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            model_eval();
            checks++; if (bus.host_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_reissue[%0d]: got %b want 0", i, bus.host_readdatavalid); end
            model_commit();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
        model_reset();
        set_idle();
        reset_n = 0;
        @(posedge clk); #1;
        test_reset();
        test_capture_only();
        test_wrap();
        test_contention();
        test_host_rw();
        test_out_of_range();
        test_clear_coincident();
        test_enable_low();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
